// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU word, register, opcode and funct types
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [5:0] {
    RTYPE   = 6'b000000,
    JAL     = 6'b000011,
    ADDIU   = 6'b001001,
    LW      = 6'b100011,
    SW      = 6'b101011,
    LL      = 6'b110000,
    SC      = 6'b111000,
    HALT_OP = 6'b111111
  } opcode_t;

  typedef enum logic [5:0] {
    SLL  = 6'b000000,
    JR   = 6'b001000,
    ADD  = 6'b100000,
    ADDU = 6'b100001,
    SUBU = 6'b100011,
    SLT  = 6'b101010
  } funct_t;

  // Writeback source priority: pcp4, then load data, then SC status, then ALU.
  function automatic word_t wb_mux(input logic wdatasrc, input word_t pcp4,
                                   input logic memtoreg, input word_t load,
                                   input logic is_sc, input logic sc_ok,
                                   input word_t alu);
    if (wdatasrc)      return pcp4;
    else if (memtoreg) return load;
    else if (is_sc)    return {31'd0, sc_ok};
    else               return alu;
  endfunction

endpackage

// File: rtl/link_reg.sv
// rtl/link_reg.sv - LL/SC link address and valid flag with store/invalidate clearing
module link_reg
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_set,
  input  word_t i_set_addr,
  input  logic  i_store,
  input  word_t i_store_addr,
  input  logic  i_inv,
  input  word_t i_inv_addr,
  input  word_t i_cmp_addr,
  output logic  o_match
);

  logic  r_valid;
  word_t r_addr;
  logic  w_clr;

  assign w_clr = (i_store && (i_store_addr == r_addr)) ||
                 (i_inv && (i_inv_addr == r_addr));

  // A new link takes priority over any clear arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
    end else if (i_set) begin
      r_valid <= 1'b1;
      r_addr  <= i_set_addr;
    end else if (w_clr) begin
      r_valid <= 1'b0;
    end
  end

  assign o_match = r_valid && (r_addr == i_cmp_addr);

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - dcache access FSM, LL/SC handling and M/WB latch
module mem_wb_stage
  import cpu_types_pkg::*;
#(
  parameter bit LINK_EN = 1'b1
) (
  input  logic     CLK,
  input  logic     nRST,
  input  logic     dREN_in,
  input  logic     dWEN_in,
  input  word_t    dmemStore_in,
  input  word_t    portO_in,
  input  logic     MemtoReg_in,
  input  regbits_t WSel_in,
  input  logic     WEN_in,
  input  logic     wdatasrc_in,
  input  word_t    pcp4_in,
  input  logic     HALT_in,
  input  opcode_t  opcode_in,
  input  funct_t   funct_in,
  input  logic     flush,
  input  logic     dhit,
  input  word_t    dmemload,
  input  logic     link_inv,
  input  word_t    link_inv_addr,
  output logic     dmemREN,
  output logic     dmemWEN,
  output word_t    dmemaddr,
  output word_t    dmemstore,
  output logic     mem_stall,
  output regbits_t WSel_out,
  output logic     WEN_out,
  output word_t    wdat_out,
  output opcode_t  opcode_out,
  output funct_t   funct_out,
  output logic     HALT_out
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t   r_state;
  logic     r_req_ren, r_req_wen, r_req_memtoreg, r_req_wen_rf, r_req_wdatasrc, r_req_halt;
  word_t    r_req_addr, r_req_store, r_req_pcp4;
  regbits_t r_req_wsel;
  opcode_t  r_req_opcode;
  funct_t   r_req_funct;

  regbits_t r_wsel_out;
  logic     r_wen_out, r_halt_out;
  word_t    r_wdat_out;
  opcode_t  r_opcode_out;
  funct_t   r_funct_out;

  logic w_memop, w_sc_fail, w_link_ok, w_hit, w_ll_hit, w_st_hit;

  assign w_memop   = (dREN_in || dWEN_in) && !flush && !r_halt_out;
  assign w_sc_fail = w_memop && (opcode_in == SC) && !w_link_ok;
  assign w_hit     = (r_state == REQ) && dhit;
  assign w_ll_hit  = w_hit && r_req_ren && (r_req_opcode == LL);
  assign w_st_hit  = w_hit && r_req_wen;

  generate
    if (LINK_EN) begin : g_link
      link_reg u_link (
        .clk          (CLK),
        .rst_n        (nRST),
        .i_set        (w_ll_hit),
        .i_set_addr   (r_req_addr),
        .i_store      (w_st_hit),
        .i_store_addr (r_req_addr),
        .i_inv        (link_inv),
        .i_inv_addr   (link_inv_addr),
        .i_cmp_addr   (portO_in),
        .o_match      (w_link_ok)
      );
    end else begin : g_nolink
      logic w_unused_link;
      assign w_unused_link = ^{link_inv, link_inv_addr, w_ll_hit, w_st_hit};
      assign w_link_ok     = 1'b1;
    end
  endgenerate

  // Stall covers the capture cycle and every REQ cycle without a hit.
  always_comb begin
    mem_stall = 1'b0;
    if (r_state == IDLE) mem_stall = w_memop && !w_sc_fail;
    else                 mem_stall = !dhit;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state        <= IDLE;
      r_req_ren      <= 1'b0;
      r_req_wen      <= 1'b0;
      r_req_addr     <= '0;
      r_req_store    <= '0;
      r_req_memtoreg <= 1'b0;
      r_req_wen_rf   <= 1'b0;
      r_req_wdatasrc <= 1'b0;
      r_req_halt     <= 1'b0;
      r_req_pcp4     <= '0;
      r_req_wsel     <= '0;
      r_req_opcode   <= RTYPE;
      r_req_funct    <= SLL;
      r_wsel_out     <= '0;
      r_wen_out      <= 1'b0;
      r_wdat_out     <= '0;
      r_opcode_out   <= RTYPE;
      r_funct_out    <= SLL;
      r_halt_out     <= 1'b0;
    end else begin
      r_wsel_out   <= '0;
      r_wen_out    <= 1'b0;
      r_wdat_out   <= '0;
      r_opcode_out <= RTYPE;
      r_funct_out  <= SLL;
      case (r_state)
        IDLE: begin
          if (w_memop && !w_sc_fail) begin
            r_state        <= REQ;
            r_req_ren      <= dREN_in;
            r_req_wen      <= dWEN_in;
            r_req_addr     <= portO_in;
            r_req_store    <= dmemStore_in;
            r_req_memtoreg <= MemtoReg_in;
            r_req_wen_rf   <= WEN_in;
            r_req_wdatasrc <= wdatasrc_in;
            r_req_halt     <= HALT_in;
            r_req_pcp4     <= pcp4_in;
            r_req_wsel     <= WSel_in;
            r_req_opcode   <= opcode_in;
            r_req_funct    <= funct_in;
          end else if (!flush && !r_halt_out) begin
            r_wsel_out   <= WSel_in;
            r_wen_out    <= WEN_in;
            r_wdat_out   <= w_sc_fail ? '0 :
                            wb_mux(wdatasrc_in, pcp4_in, 1'b0, '0, 1'b0, 1'b0, portO_in);
            r_opcode_out <= opcode_in;
            r_funct_out  <= funct_in;
            r_halt_out   <= HALT_in;
          end
        end
        REQ: begin
          // flush is deliberately ignored here: the request always completes.
          if (dhit) begin
            r_state      <= IDLE;
            r_req_ren    <= 1'b0;
            r_req_wen    <= 1'b0;
            r_req_addr   <= '0;
            r_req_store  <= '0;
            r_wsel_out   <= r_req_wsel;
            r_wen_out    <= r_req_wen_rf;
            r_wdat_out   <= wb_mux(r_req_wdatasrc, r_req_pcp4, r_req_memtoreg, dmemload,
                                   r_req_opcode == SC, 1'b1, r_req_addr);
            r_opcode_out <= r_req_opcode;
            r_funct_out  <= r_req_funct;
            r_halt_out   <= r_req_halt;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dmemREN    = r_req_ren;
  assign dmemWEN    = r_req_wen;
  assign dmemaddr   = r_req_addr;
  assign dmemstore  = r_req_store;
  assign WSel_out   = r_wsel_out;
  assign WEN_out    = r_wen_out;
  assign wdat_out   = r_wdat_out;
  assign opcode_out = r_opcode_out;
  assign funct_out  = r_funct_out;
  assign HALT_out   = r_halt_out;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed vector and sequence bench for mem_wb_stage
module tb_mem_wb_stage;
  import cpu_types_pkg::*;

  logic     CLK, nRST;
  logic     dREN_in, dWEN_in, MemtoReg_in, WEN_in, wdatasrc_in, HALT_in, flush, dhit, link_inv;
  word_t    dmemStore_in, portO_in, pcp4_in, dmemload, link_inv_addr;
  regbits_t WSel_in, WSel_out;
  opcode_t  opcode_in, opcode_out;
  funct_t   funct_in, funct_out;
  logic     dmemREN, dmemWEN, mem_stall, WEN_out, HALT_out;
  word_t    dmemaddr, dmemstore, wdat_out;

  int n_cmp = 0;
  int n_fail = 0;

  mem_wb_stage #(.LINK_EN(1'b1)) dut (
    .CLK(CLK), .nRST(nRST), .dREN_in(dREN_in), .dWEN_in(dWEN_in),
    .dmemStore_in(dmemStore_in), .portO_in(portO_in), .MemtoReg_in(MemtoReg_in),
    .WSel_in(WSel_in), .WEN_in(WEN_in), .wdatasrc_in(wdatasrc_in), .pcp4_in(pcp4_in),
    .HALT_in(HALT_in), .opcode_in(opcode_in), .funct_in(funct_in), .flush(flush),
    .dhit(dhit), .dmemload(dmemload), .link_inv(link_inv), .link_inv_addr(link_inv_addr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .WSel_out(WSel_out), .WEN_out(WEN_out), .wdat_out(wdat_out),
    .opcode_out(opcode_out), .funct_out(funct_out), .HALT_out(HALT_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    opcode_t  op;
    funct_t   fn;
    logic     dren, dwen, fl, wen, wsrc;
    regbits_t wsel;
    word_t    porto, pcp4;
    logic     exp_stall, exp_wen;
    word_t    exp_wdat;
    regbits_t exp_wsel;
    funct_t   exp_fn;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_nop();
    dREN_in = 1'b0; dWEN_in = 1'b0; MemtoReg_in = 1'b0; WEN_in = 1'b0;
    wdatasrc_in = 1'b0; HALT_in = 1'b0; flush = 1'b0;
    dmemStore_in = '0; portO_in = '0; pcp4_in = '0; WSel_in = '0;
    opcode_in = RTYPE; funct_in = SLL;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic mem_access(input string tag, input opcode_t op, input word_t addr,
                            input word_t data, input int delay, input word_t load,
                            input logic flush_req, input logic inv_on_hit,
                            input logic exp_issue, input word_t exp_wdat);
    logic is_ld, rf;
    int   stalls;
    is_ld = (op == LW) || (op == LL);
    rf    = is_ld || (op == SC);
    opcode_in = op; funct_in = SLL;
    dREN_in = is_ld; dWEN_in = !is_ld; MemtoReg_in = is_ld; WEN_in = rf;
    portO_in = addr; dmemStore_in = data; WSel_in = 5'd10;
    stalls = 0;
    #1;
    chk({tag, " capture stall"}, 32'(mem_stall), 32'(exp_issue));
    if (mem_stall) stalls++;
    if (exp_issue) begin
      tick();
      chk({tag, " dmemREN"}, 32'(dmemREN), 32'(is_ld));
      chk({tag, " dmemWEN"}, 32'(dmemWEN), 32'(!is_ld));
      chk({tag, " dmemaddr"}, dmemaddr, addr);
      chk({tag, " dmemstore"}, dmemstore, data);
      flush = flush_req;
      for (int i = 0; i < delay; i++) begin
        if (mem_stall) stalls++;
        tick();
      end
      chk({tag, " req held"}, 32'({dmemREN, dmemWEN}), 32'({is_ld, !is_ld}));
      dhit = 1'b1; dmemload = load;
      if (inv_on_hit) begin
        link_inv = 1'b1; link_inv_addr = addr;
      end
      #1;
      chk({tag, " hit stall"}, 32'(mem_stall), 32'd0);
      tick();
      dhit = 1'b0; link_inv = 1'b0; flush = 1'b0;
      chk({tag, " stall cycles"}, 32'(stalls), 32'(delay + 1));
      chk({tag, " req released"}, 32'({dmemREN, dmemWEN}), 32'd0);
    end else begin
      tick();
      chk({tag, " no request"}, 32'({dmemREN, dmemWEN}), 32'd0);
    end
    chk({tag, " WEN_out"}, 32'(WEN_out), 32'(rf));
    chk({tag, " wdat_out"}, wdat_out, exp_wdat);
    set_nop();
  endtask

  task automatic inv_cycle(input word_t addr);
    link_inv = 1'b1; link_inv_addr = addr;
    tick();
    link_inv = 1'b0;
  endtask

  initial begin
    vecs[0] = '{RTYPE, ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'h10, 32'h4,
                1'b0, 1'b1, 32'h10, 5'd5, ADD};
    vecs[1] = '{JAL, SLL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd31, 32'h99, 32'h404,
                1'b0, 1'b1, 32'h404, 5'd31, SLL};
    vecs[2] = '{ADDIU, SLL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 32'hFFFF_FFFF, 32'h8,
                1'b0, 1'b0, 32'hFFFF_FFFF, 5'd3, SLL};
    vecs[3] = '{LW, SLL, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd8, 32'h100, 32'h0,
                1'b0, 1'b0, 32'h0, 5'd0, SLL};
    vecs[4] = '{RTYPE, ADDU, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 32'h55, 32'h0,
                1'b0, 1'b0, 32'h0, 5'd0, SLL};
    vecs[5] = '{SC, SLL, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 32'h300, 32'h0,
                1'b0, 1'b1, 32'h0, 5'd9, SLL};

    nRST = 1'b0; dhit = 1'b0; dmemload = '0; link_inv = 1'b0; link_inv_addr = '0;
    set_nop();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset dmemREN", 32'(dmemREN), 32'd0);
    chk("reset dmemWEN", 32'(dmemWEN), 32'd0);
    chk("reset dmemaddr", dmemaddr, 32'd0);
    chk("reset dmemstore", dmemstore, 32'd0);
    chk("reset mem_stall", 32'(mem_stall), 32'd0);
    chk("reset WEN_out", 32'(WEN_out), 32'd0);
    chk("reset WSel_out", 32'(WSel_out), 32'd0);
    chk("reset wdat_out", wdat_out, 32'd0);
    chk("reset opcode_out", 32'(opcode_out), 32'd0);
    chk("reset HALT_out", 32'(HALT_out), 32'd0);
    nRST = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      opcode_in = vecs[v].op; funct_in = vecs[v].fn;
      dREN_in = vecs[v].dren; dWEN_in = vecs[v].dwen; flush = vecs[v].fl;
      WEN_in = vecs[v].wen; wdatasrc_in = vecs[v].wsrc; WSel_in = vecs[v].wsel;
      portO_in = vecs[v].porto; pcp4_in = vecs[v].pcp4;
      #1;
      chk($sformatf("vec%0d mem_stall", v), 32'(mem_stall), 32'(vecs[v].exp_stall));
      tick();
      chk($sformatf("vec%0d dmemREN", v), 32'(dmemREN), 32'd0);
      chk($sformatf("vec%0d WEN_out", v), 32'(WEN_out), 32'(vecs[v].exp_wen));
      chk($sformatf("vec%0d wdat_out", v), wdat_out, vecs[v].exp_wdat);
      chk($sformatf("vec%0d WSel_out", v), 32'(WSel_out), 32'(vecs[v].exp_wsel));
      chk($sformatf("vec%0d funct_out", v), 32'(funct_out), 32'(vecs[v].exp_fn));
    end
    set_nop();
    tick();

    mem_access("lw slow", LW, 32'h100, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);

    mem_access("ll a", LL, 32'h200, 32'h0, 0, 32'h7, 1'b0, 1'b0, 1'b1, 32'h7);
    mem_access("sc a ok", SC, 32'h200, 32'h55, 1, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1);
    mem_access("sc a again", SC, 32'h200, 32'h55, 0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    mem_access("ll b", LL, 32'h200, 32'h0, 0, 32'h11, 1'b0, 1'b0, 1'b1, 32'h11);
    inv_cycle(32'h200);
    mem_access("sc b inv", SC, 32'h200, 32'h56, 0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    mem_access("ll c", LL, 32'h200, 32'h0, 0, 32'h22, 1'b0, 1'b1, 1'b1, 32'h22);
    mem_access("sc c", SC, 32'h200, 32'h57, 0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1);

    mem_access("ll d", LL, 32'h200, 32'h0, 0, 32'h33, 1'b0, 1'b0, 1'b1, 32'h33);
    inv_cycle(32'h204);
    mem_access("sc d", SC, 32'h200, 32'h58, 0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1);

    mem_access("ll e", LL, 32'h200, 32'h0, 0, 32'h44, 1'b0, 1'b0, 1'b1, 32'h44);
    mem_access("sw e", SW, 32'h200, 32'h9, 0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h200);
    mem_access("sc e", SC, 32'h200, 32'h59, 0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    mem_access("sw flush", SW, 32'h400, 32'hA5, 2, 32'h0, 1'b1, 1'b0, 1'b1, 32'h400);

    opcode_in = HALT_OP; HALT_in = 1'b1;
    tick();
    chk("halt set", 32'(HALT_out), 32'd1);
    set_nop();
    repeat (2) tick();
    chk("halt sticky", 32'(HALT_out), 32'd1);
    opcode_in = LW; dREN_in = 1'b1; MemtoReg_in = 1'b1; WEN_in = 1'b1; portO_in = 32'h100;
    #1;
    chk("halted lw stall", 32'(mem_stall), 32'd0);
    tick();
    chk("halted lw dmemREN", 32'(dmemREN), 32'd0);
    set_nop();
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
    tick();
    chk("halt cleared by reset", 32'(HALT_out), 32'd0);

    mem_access("ll f", LL, 32'h600, 32'h0, 0, 32'h66, 1'b0, 1'b0, 1'b1, 32'h66);
    opcode_in = LW; dREN_in = 1'b1; MemtoReg_in = 1'b1; WEN_in = 1'b1; portO_in = 32'h500;
    tick();
    chk("rst lw dmemREN before", 32'(dmemREN), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("rst lw dmemREN after", 32'(dmemREN), 32'd0);
    chk("rst lw dmemaddr after", dmemaddr, 32'd0);
    set_nop();
    #1;
    nRST = 1'b1;
    mem_access("sc f after rst", SC, 32'h600, 32'h77, 0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer end of the EX/M pipeline latch.
- Takes the EX/M latch outputs and performs the data-memory access against the dcache, including the dREN/dWEN request and dhit handshake.
- Implements LL/SC link tracking and registers results into the M/WB latch consumed by writeback.
- Generates the memory-stage stall back to the hazard unit and the upstream latches.

Parameters:
- LINK_EN, 1: 1 = LL/SC link register implemented; 0 = SC always succeeds and LL behaves as LW.

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- dREN_in  in  1  load request from EX/M
- dWEN_in  in  1  store request from EX/M
- dmemStore_in  in  32  store data
- portO_in  in  32  ALU result / memory address
- MemtoReg_in  in  1  writeback selects load data
- WSel_in  in  5  destination register
- WEN_in  in  1  register write enable
- wdatasrc_in  in  1  writeback selects pcp4
- pcp4_in  in  32  PC+4
- HALT_in  in  1  halt instruction
- opcode_in  in  6  opcode_t
- funct_in  in  6  funct_t
- flush  in  1  squash the current EX/M contents
- dhit  in  1  dcache access complete
- dmemload  in  32  dcache read data
- link_inv  in  1  coherence invalidate strobe
- link_inv_addr  in  32  invalidated address
- dmemREN  out  1  dcache read request
- dmemWEN  out  1  dcache write request
- dmemaddr  out  32  dcache address
- dmemstore  out  32  dcache write data
- mem_stall  out  1  hold PC and all upstream latches
- WSel_out  out  5  M/WB destination register
- WEN_out  out  1  M/WB write enable
- wdat_out  out  32  M/WB final write data (mux resolved)
- opcode_out  out  6  M/WB opcode, for forwarding/debug
- funct_out  out  6  M/WB funct
- HALT_out  out  1  sticky halt

Behaviour:
- Reset values: FSM=IDLE, all outputs 0, link_valid=0, link_addr=0.
- FSM IDLE:
  - memop = (dREN_in|dWEN_in) & ~flush & ~HALT_out.
  - If memop and the instruction is SC with the link failed: no access, 1-cycle pass, wdat=0.
  - Otherwise, if memop: capture addr/data/ctrl into request registers, go to REQ, mem_stall=1.
  - Non-memop: pass through in 1 cycle, mem_stall=0.
- FSM REQ:
  - dmemREN/dmemWEN/dmemaddr/dmemstore are driven from the request registers only, so they are glitch-free.
  - When !dhit: stall=1.
  - When dhit: stall=0, M/WB latches the result at the same edge, return to IDLE.
- Minimum latency for a memop is 2 cycles (capture + hit cycle).
- Request outputs are 0 in IDLE.
- wdat_out mux:
  - wdatasrc → pcp4.
  - else MemtoReg → dmemload (captured on dhit).
  - else SC → 1 on success.
  - else portO.
- Insertion rules:
  - When stalled, M/WB takes a bubble: WEN_out=0, HALT not advanced.
  - flush in IDLE → bubble.
  - flush in REQ is ignored: an in-flight request always completes.
- Link register:
  - LL hit → link_addr=addr, link_valid=1.
  - SC success on hit → link_valid=0.
  - SC success requires link_valid & link_addr==portO_in.
  - Any store hit to link_addr → clear link_valid.
  - link_inv with matching address → clear link_valid.
  - Simultaneous LL hit and invalidate → LL wins (set).
- HALT_out is set when a HALT instruction enters M/WB and stays set until reset. Once set, no new requests are issued.
- Reset mid-REQ: requests drop immediately and asynchronously. The FSM returns to IDLE and the link is cleared.

Decomposition:
- Shared cpu_types_pkg supplies word_t, regbits_t, opcode_t, funct_t, and the LL/SC/LW/SW opcode constants.
- The FSM state enum stays local to this module.
- One sub-module: link_reg (link address/valid register, set/clear/compare logic), instantiated when LINK_EN=1.

Test Plan:
1. ADD, portO=0x0000_0010, WEN=1, WSel=5 → next edge WEN_out=1, wdat_out=0x10, mem_stall never asserted.
2. LW at addr 0x100, dhit delayed 3 cycles, dmemload=0xDEADBEEF → mem_stall high 4 cycles, dmemREN=1 from cycle 2, wdat_out=0xDEADBEEF on release.
3. LL 0x200 then SC 0x200 data 0x55 → SC issues dmemWEN, wdat_out=1. A second SC to 0x200 → no dmemWEN, wdat_out=0, 1-cycle.
4. LL 0x200, link_inv addr 0x200, then SC 0x200 → SC fails, wdat_out=0. Also: LL hit coincident with link_inv → a following SC succeeds.
5. SW in REQ with flush asserted → store still completes on dhit. flush in IDLE on an LW → no dmemREN, WEN_out=0.
6. HALT passes → HALT_out=1 and sticky; a subsequent LW issues no request. nRST low mid-REQ → dmemREN=0 immediately.
